ssd_scan_driver: RTL

Parametrised, time-multiplexed seven-segment display driver for the debug front panels on the Nexys A7 Manta examples. It generalises the fixed 8-digit hex display to NUM_DIGITS digits and adds four features:
- tear-free frame-boundary value update
- per-digit decimal points
- optional leading-zero blanking
- PWM brightness control

It sits in the top level beside the Manta core and displays probe/RAM values on the 50 MHz Ethernet-side clock.

---
 rtl/ssd_pkg.sv | 18 +
 rtl/ssd_scan_driver_if.sv | 16 +
 rtl/ssd_hex_decode.sv | 13 +
 rtl/ssd_scan_driver.sv | 137 +++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment scan driver.
//   seg_t        : active-high segment vector {g,f,e,d,c,b,a}
//   SEG_BLANK    : active-low "all segments off" pattern
//   HEX_SEG_LUT  : hex digit -> active-high segment pattern
package ssd_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  localparam seg_t HEX_SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
    7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
    7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
    7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
  };

endpackage

// File: rtl/ssd_scan_driver_if.sv
// Value-load bus into the scan driver.
//   val       : hex value, nibble i drives digit i
//   val_valid : load strobe for val and dp
//   dp        : per-digit decimal point enable, active high
interface ssd_scan_driver_if #(
  parameter int unsigned NUM_DIGITS = 8
);

  logic [4*NUM_DIGITS-1:0] val;
  logic                    val_valid;
  logic [NUM_DIGITS-1:0]   dp;

  modport master (output val, output val_valid, output dp);
  modport slave  (input  val, input  val_valid, input  dp);

endinterface

// File: rtl/ssd_hex_decode.sv
// Combinational hex nibble to active-high segment decoder.
//   nibble : 4-bit hex digit
//   seg_c  : active-high segments {g,f,e,d,c,b,a}
module ssd_hex_decode
  import ssd_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg_c
);

  assign seg_c = HEX_SEG_LUT[nibble];

endmodule

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed seven-segment display driver with frame-synchronous value
// update, per-digit decimal points, leading-zero blanking and PWM brightness.
//   clk, rst   : clock and synchronous active-high reset
//   load       : value-load bus (val, val_valid, dp)
//   blank_lz   : leading-zero blanking enable, taken at frame boundary
//   brightness : duty control, taken at frame boundary
//   cat, dp_n  : active-low segments and decimal point
//   an         : active-low anodes
//   frame_done : one-cycle pulse after the last cycle of each frame
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned REFRESH_DIV = 6250,
  parameter int unsigned BRIGHT_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  ssd_scan_driver_if.slave      load,
  input  logic                  blank_lz,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [6:0]            cat,
  output logic                  dp_n,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_done
);

  localparam int unsigned SLOT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned DIGIT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned THR_W   = $clog2(REFRESH_DIV) + BRIGHT_W + 1;
  localparam int unsigned VAL_W   = 4 * NUM_DIGITS;

  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(NUM_DIGITS - 1);
  localparam logic [THR_W-1:0]   THR_FULL   = THR_W'(REFRESH_DIV);

  logic [SLOT_W-1:0]     slot_cnt;
  logic [DIGIT_W-1:0]    digit;
  logic [VAL_W-1:0]      pend_val;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic [VAL_W-1:0]      disp_val;
  logic [NUM_DIGITS-1:0] disp_dp;
  logic                  blank_lz_r;
  logic [THR_W-1:0]      threshold;

  logic                  slot_wrap;
  logic                  frame_end;
  logic [THR_W-1:0]      thr_next;
  logic [3:0]            nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] blanked;
  logic [3:0]            cur_nib;
  seg_t                  cur_seg;
  logic                  lit;
  logic [NUM_DIGITS-1:0] an_next;

  assign slot_wrap = (slot_cnt == SLOT_LAST);
  assign frame_end = slot_wrap && (digit == DIGIT_LAST);

  // On-time in clk cycles per slot: (brightness+1)/2**BRIGHT_W of the slot.
  assign thr_next = THR_W'(((THR_W'(brightness) + THR_W'(1)) * THR_FULL) >> BRIGHT_W);

  // Digit i>0 is blank when it and every more-significant nibble are zero.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    assign nib[i] = disp_val[4*i +: 4];
    if (i == 0) begin : g_lsd
      assign blanked[i] = 1'b0;
    end else begin : g_upper
      assign blanked[i] = blank_lz_r && (disp_val[VAL_W-1:4*i] == '0);
    end
  end

  assign cur_nib = nib[digit];

  ssd_hex_decode u_hex_decode (
    .nibble (cur_nib),
    .seg_c  (cur_seg)
  );

  assign lit = (THR_W'(slot_cnt) < threshold) && !blanked[digit];

  // Only the scanned digit can pull its anode low.
  always_comb begin
    an_next = '1;
    if (lit) an_next[digit] = 1'b0;
  end

  // Slot and digit scan counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt <= '0;
      digit    <= '0;
    end else begin
      slot_cnt <= slot_wrap ? '0 : slot_cnt + SLOT_W'(1);
      if (slot_wrap) digit <= (digit == DIGIT_LAST) ? '0 : digit + DIGIT_W'(1);
    end
  end

  // Pending capture on any strobe; display state swaps only at frame end,
  // with a strobe on that same cycle bypassing the pending registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_val   <= '0;
      pend_dp    <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      blank_lz_r <= 1'b0;
      threshold  <= THR_FULL;
    end else begin
      if (load.val_valid) begin
        pend_val <= load.val;
        pend_dp  <= load.dp;
      end
      if (frame_end) begin
        disp_val   <= load.val_valid ? load.val : pend_val;
        disp_dp    <= load.val_valid ? load.dp  : pend_dp;
        blank_lz_r <= blank_lz;
        threshold  <= thr_next;
      end
    end
  end

  // Registered panel outputs, dark whenever no anode is lit.
  always_ff @(posedge clk) begin
    if (rst) begin
      an         <= '1;
      cat        <= SEG_BLANK;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= an_next;
      cat        <= lit ? ~cur_seg : SEG_BLANK;
      dp_n       <= lit ? ~disp_dp[digit] : 1'b1;
      frame_done <= frame_end;
    end
  end

endmodule
